// File: rtl/fifo_gen2_if.sv
// Handshake/status bundle for fifo_gen2. The producer/consumer side uses the
// master modport; the FIFO itself uses the slave modport.
interface fifo_gen2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en_in;
    logic                  rd_en_in;
    logic                  err_clr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty_out;
    logic                  full_out;
    logic                  almost_full_out;
    logic                  almost_empty_out;
    logic [CNT_W-1:0]      count_out;
    logic                  overflow_out;
    logic                  underflow_out;

    modport master (
        output flush_in, data_in, wr_en_in, rd_en_in, err_clr_in,
        input  data_out, empty_out, full_out, almost_full_out,
               almost_empty_out, count_out, overflow_out, underflow_out
    );

    modport slave (
        input  flush_in, data_in, wr_en_in, rd_en_in, err_clr_in,
        output data_out, empty_out, full_out, almost_full_out,
               almost_empty_out, count_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/fifo_gen2.sv
// Synchronous first-word-fall-through FIFO with arbitrary (non power-of-two)
// depth, registered occupancy counter, almost-full/empty thresholds and
// sticky overflow/underflow flags. Every output decodes from registered state.
module fifo_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_gen2_if.slave    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Storage is deliberately not reset; data_out is masked by count instead.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             not_empty;
    logic             not_full;
    logic             rd_acc;
    logic             wr_acc;
    logic             wr_rej;
    logic             rd_rej;
    int               cnt_int;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != DEPTH_C);

    // Flush masks both requests, so it neither moves data nor raises errors.
    assign rd_acc = bus.rd_en_in & not_empty & ~bus.flush_in;
    assign wr_acc = bus.wr_en_in & (not_full | rd_acc) & ~bus.flush_in;
    assign wr_rej = bus.wr_en_in & ~bus.flush_in & ~wr_acc;
    assign rd_rej = bus.rd_en_in & ~bus.flush_in & ~not_empty;

    // Next-state: pointers wrap at DEPTH-1, count tracks net push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_acc)
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            if (wr_acc)
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (wr_acc && !rd_acc)
                count_d = count_q + 1'b1;
            else if (rd_acc && !wr_acc)
                count_d = count_q - 1'b1;
        end
    end

    // Sticky flags: a fresh error in the same cycle outranks err_clr.
    always_comb begin
        ovf_d = ovf_q & ~bus.err_clr_in;
        unf_d = unf_q & ~bus.err_clr_in;
        if (wr_rej)
            ovf_d = 1'b1;
        if (rd_rej)
            unf_d = 1'b1;
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= bus.data_in;
    end

    // Signed view of the count so thresholds of any value compare cleanly.
    assign cnt_int = int'(count_q);

    assign bus.data_out         = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.empty_out        = ~not_empty;
    assign bus.full_out         = ~not_full;
    assign bus.almost_full_out  = (cnt_int >= AF_THRESH);
    assign bus.almost_empty_out = (cnt_int <= AE_THRESH);
    assign bus.count_out        = count_q;
    assign bus.overflow_out     = ovf_q;
    assign bus.underflow_out    = unf_q;
endmodule

// File: tb/tb_fifo_gen2.sv
// Directed bench for fifo_gen2 at DEPTH=5 (default thresholds: AF=3, AE=2).
module tb_fifo_gen2;
    localparam int DW    = 8;
    localparam int DEPTH = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   nvec    = 0;
    int   nerr    = 0;

    always #5 clk = ~clk;

    fifo_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en_in   = 1'b0;
        bus.rd_en_in   = 1'b0;
        bus.flush_in   = 1'b0;
        bus.err_clr_in = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.data_in = 8'h00;
        reset_n = 1'b0;
        #12;
        nvec++; if (bus.count_out !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d exp 0", bus.count_out); end
        nvec++; if (bus.empty_out !== 1'b1) begin nerr++; $display("FAIL rst_empty got %b exp 1", bus.empty_out); end
        nvec++; if (bus.full_out !== 1'b0) begin nerr++; $display("FAIL rst_full got %b exp 0", bus.full_out); end
        nvec++; if (bus.almost_empty_out !== 1'b1) begin nerr++; $display("FAIL rst_ae got %b exp 1", bus.almost_empty_out); end
        nvec++; if (bus.almost_full_out !== 1'b0) begin nerr++; $display("FAIL rst_af got %b exp 0", bus.almost_full_out); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL rst_data got %h exp 00", bus.data_out); end
        nvec++; if (bus.overflow_out !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b exp 0", bus.overflow_out); end
        nvec++; if (bus.underflow_out !== 1'b0) begin nerr++; $display("FAIL rst_unf got %b exp 0", bus.underflow_out); end
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(8'h11 + i);
            cyc();
            nvec++; if (bus.count_out !== 3'(i + 1)) begin nerr++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count_out, i + 1); end
            nvec++; if (bus.almost_full_out !== (i + 1 >= 3)) begin nerr++; $display("FAIL fill_af[%0d] got %b exp %b", i, bus.almost_full_out, (i + 1 >= 3)); end
            nvec++; if (bus.full_out !== (i == 4)) begin nerr++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.full_out, (i == 4)); end
            nvec++; if (bus.data_out !== 8'h11) begin nerr++; $display("FAIL fill_head[%0d] got %h exp 11", i, bus.data_out); end
        end
        bus.data_in = 8'h16;
        cyc();
        idle();
        nvec++; if (bus.overflow_out !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b exp 1", bus.overflow_out); end
        nvec++; if (bus.count_out !== 3'd5) begin nerr++; $display("FAIL ovf_count got %0d exp 5", bus.count_out); end
        nvec++; if (bus.data_out !== 8'h11) begin nerr++; $display("FAIL ovf_head got %h exp 11", bus.data_out); end
        for (int i = 0; i < 5; i++) begin
            nvec++; if (bus.data_out !== 8'(8'h11 + i)) begin nerr++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.data_out, 8'(8'h11 + i)); end
            bus.rd_en_in = 1'b1;
            cyc();
            nvec++; if (bus.count_out !== 3'(4 - i)) begin nerr++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, bus.count_out, 4 - i); end
            nvec++; if (bus.almost_empty_out !== (4 - i <= 2)) begin nerr++; $display("FAIL drain_ae[%0d] got %b exp %b", i, bus.almost_empty_out, (4 - i <= 2)); end
        end
        idle();
        nvec++; if (bus.empty_out !== 1'b1) begin nerr++; $display("FAIL drain_empty got %b exp 1", bus.empty_out); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL drain_zero got %h exp 00", bus.data_out); end
        nvec++; if (bus.overflow_out !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow_out); end
        bus.err_clr_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.overflow_out !== 1'b0) begin nerr++; $display("FAIL ovf_clr got %b exp 0", bus.overflow_out); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(8'hA0 + i);
            cyc();
            idle();
            nvec++; if (bus.data_out !== 8'(8'hA0 + i)) begin nerr++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus.data_out, 8'(8'hA0 + i)); end
            nvec++; if (bus.empty_out !== 1'b0) begin nerr++; $display("FAIL wrap_nempty[%0d] got %b exp 0", i, bus.empty_out); end
            bus.rd_en_in = 1'b1;
            cyc();
            idle();
            nvec++; if (bus.count_out !== 3'd0) begin nerr++; $display("FAIL wrap_count[%0d] got %0d exp 0", i, bus.count_out); end
        end
    endtask

    task automatic test_underflow();
        bus.rd_en_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.underflow_out !== 1'b1) begin nerr++; $display("FAIL unf_set got %b exp 1", bus.underflow_out); end
        nvec++; if (bus.count_out !== 3'd0) begin nerr++; $display("FAIL unf_count got %0d exp 0", bus.count_out); end
        bus.wr_en_in = 1'b1;
        bus.rd_en_in = 1'b1;
        bus.data_in  = 8'h5A;
        cyc();
        idle();
        nvec++; if (bus.count_out !== 3'd1) begin nerr++; $display("FAIL rw_empty_count got %0d exp 1", bus.count_out); end
        nvec++; if (bus.data_out !== 8'h5A) begin nerr++; $display("FAIL rw_empty_data got %h exp 5a", bus.data_out); end
        bus.err_clr_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.underflow_out !== 1'b0) begin nerr++; $display("FAIL unf_clr got %b exp 0", bus.underflow_out); end
    endtask

    task automatic test_full_rw();
        logic [7:0] old [5];
        old = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i < 5; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(i);
            cyc();
        end
        idle();
        nvec++; if (bus.full_out !== 1'b1) begin nerr++; $display("FAIL frw_full0 got %b exp 1", bus.full_out); end
        for (int k = 0; k < 5; k++) begin
            nvec++; if (bus.data_out !== old[k]) begin nerr++; $display("FAIL frw_data[%0d] got %h exp %h", k, bus.data_out, old[k]); end
            bus.wr_en_in = 1'b1;
            bus.rd_en_in = 1'b1;
            bus.data_in  = 8'h77;
            cyc();
            nvec++; if (bus.count_out !== 3'd5 || bus.full_out !== 1'b1) begin nerr++; $display("FAIL frw_hold[%0d] got count %0d full %b exp 5/1", k, bus.count_out, bus.full_out); end
        end
        idle();
        nvec++; if (bus.data_out !== 8'h77) begin nerr++; $display("FAIL frw_new got %h exp 77", bus.data_out); end
        nvec++; if (bus.overflow_out !== 1'b0) begin nerr++; $display("FAIL frw_ovf got %b exp 0", bus.overflow_out); end
    endtask

    task automatic test_flush();
        bus.flush_in = 1'b1;
        bus.wr_en_in = 1'b1;
        bus.data_in  = 8'h99;
        cyc();
        idle();
        nvec++; if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1) begin nerr++; $display("FAIL flush_full got count %0d empty %b exp 0/1", bus.count_out, bus.empty_out); end
        for (int i = 0; i < 3; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(8'hC1 + i);
            cyc();
        end
        idle();
        nvec++; if (bus.count_out !== 3'd3) begin nerr++; $display("FAIL flush_pre got %0d exp 3", bus.count_out); end
        bus.flush_in = 1'b1;
        bus.wr_en_in = 1'b1;
        bus.data_in  = 8'hEE;
        cyc();
        idle();
        nvec++; if (bus.count_out !== 3'd0) begin nerr++; $display("FAIL flush3_count got %0d exp 0", bus.count_out); end
        nvec++; if (bus.empty_out !== 1'b1) begin nerr++; $display("FAIL flush3_empty got %b exp 1", bus.empty_out); end
        nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL flush3_data got %h exp 00", bus.data_out); end
        bus.flush_in = 1'b1;
        bus.rd_en_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.underflow_out !== 1'b0) begin nerr++; $display("FAIL flush_nounf got %b exp 0", bus.underflow_out); end
        for (int i = 0; i < 5; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(8'hD1 + i);
            cyc();
        end
        idle();
        nvec++; if (bus.data_out !== 8'hD1) begin nerr++; $display("FAIL flush_after got %h exp d1", bus.data_out); end
        bus.wr_en_in   = 1'b1;
        bus.err_clr_in = 1'b1;
        bus.data_in    = 8'hFF;
        cyc();
        idle();
        nvec++; if (bus.overflow_out !== 1'b1) begin nerr++; $display("FAIL clr_prio got %b exp 1", bus.overflow_out); end
        bus.flush_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.overflow_out !== 1'b1 || bus.count_out !== 3'd0) begin nerr++; $display("FAIL flush_keep got ovf %b count %0d exp 1/0", bus.overflow_out, bus.count_out); end
        bus.err_clr_in = 1'b1;
        cyc();
        idle();
        nvec++; if (bus.overflow_out !== 1'b0) begin nerr++; $display("FAIL clr_only got %b exp 0", bus.overflow_out); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr_en_in = 1'b1;
            bus.data_in  = 8'(8'hE0 + i);
            cyc();
        end
        idle();
        bus.rd_en_in = 1'b1;
        cyc();
        idle();
        bus.wr_en_in = 1'b1;
        bus.data_in  = 8'hE4;
        cyc();
        idle();
        nvec++; if (bus.count_out !== 3'd4 || bus.almost_full_out !== 1'b1) begin nerr++; $display("FAIL ar_pre got count %0d af %b exp 4/1", bus.count_out, bus.almost_full_out); end
        #3;
        reset_n = 1'b0;
        #1;
        nvec++; if (bus.count_out !== 3'd0 || bus.empty_out !== 1'b1 || bus.full_out !== 1'b0) begin nerr++; $display("FAIL ar_cnt got count %0d empty %b full %b exp 0/1/0", bus.count_out, bus.empty_out, bus.full_out); end
        nvec++; if (bus.almost_empty_out !== 1'b1 || bus.almost_full_out !== 1'b0) begin nerr++; $display("FAIL ar_thr got ae %b af %b exp 1/0", bus.almost_empty_out, bus.almost_full_out); end
        nvec++; if (bus.data_out !== 8'h00 || bus.overflow_out !== 1'b0 || bus.underflow_out !== 1'b0) begin nerr++; $display("FAIL ar_data got data %h ovf %b unf %b exp 00/0/0", bus.data_out, bus.overflow_out, bus.underflow_out); end
        cyc();
        reset_n = 1'b1;
        bus.wr_en_in = 1'b1;
        bus.data_in  = 8'h3C;
        cyc();
        idle();
        nvec++; if (bus.data_out !== 8'h3C || bus.count_out !== 3'd1) begin nerr++; $display("FAIL ar_first got data %h count %0d exp 3c/1", bus.data_out, bus.count_out); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_underflow();
        test_full_rw();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
